// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: operand forwarding,
// load-use and HI/LO stalls, branch flushes, MULT/DIV scheduling and a stall counter.
module pipe_hazard_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_hilo_use,
   input  logic [4:0]  ex_rs,
   input  logic [4:0]  ex_rt,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        ex_md_start,
   input  logic        ex_md_is_div,
   input  logic [4:0]  mem_rd,
   input  logic [4:0]  wb_rd,
   input  logic        mem_reg_write,
   input  logic        wb_reg_write,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic [1:0]  forward_a,
   output logic [1:0]  forward_b,
   output logic        md_busy,
   output logic        md_done,
   output logic        md_overlap,
   output logic [31:0] stall_cycles
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        md_overlap_q, md_overlap_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   logic        busy_int, done_int, load_use, hilo_haz;

   // MEM is the younger producer, so it wins over WB; $0 never forwards.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic       m_we, input logic [4:0] m_rd,
                                          input logic       w_we, input logic [4:0] w_rd);
      if (m_we && m_rd != 5'd0 && m_rd == src)
         return 2'b01;
      else if (w_we && w_rd != 5'd0 && w_rd == src)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      busy_int = (state_q == ST_BUSY) && (cnt_q != 8'd0);
      done_int = (state_q == ST_BUSY) && (cnt_q == 8'd0);
      load_use = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      hilo_haz = busy_int && id_hilo_use;

      forward_a  = fwd_sel(ex_rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      forward_b  = fwd_sel(ex_rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      md_busy    = busy_int;
      md_done    = done_int;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;

      // A taken branch squashes the stalled instruction anyway, so it overrides the stall.
      if (rst) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         forward_a  = 2'b00;
         forward_b  = 2'b00;
         md_busy    = 1'b0;
         md_done    = 1'b0;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use || hilo_haz) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      md_overlap_d   = md_overlap_q | (ex_md_start && state_q == ST_BUSY);
      stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
      case (state_q)
         ST_IDLE: begin
            if (ex_md_start) begin
               state_d = ST_BUSY;
               cnt_d   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
            end
         end
         default: begin
            if (cnt_q == 8'd0)
               state_d = ST_IDLE;
            else
               cnt_d = cnt_q - 8'd1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 8'd0;
         md_overlap_q   <= 1'b0;
         stall_cycles_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         md_overlap_q   <= md_overlap_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign md_overlap   = md_overlap_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-count reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int MUL_N = 4;
   localparam int DIV_N = 32;

   typedef struct {
      logic       rst;
      logic [4:0] id_rs, id_rt;
      logic       id_uses_rs, id_uses_rt, id_hilo_use;
      logic [4:0] ex_rs, ex_rt, ex_rd;
      logic       ex_mem_read, ex_branch_taken, ex_md_start, ex_md_is_div;
      logic [4:0] mem_rd, wb_rd;
      logic       mem_reg_write, wb_reg_write;
   } stim_t;

   typedef struct {
      logic        pc_en, ifid_en, ifid_flush, idex_flush;
      logic [1:0]  fa, fb;
      logic        md_busy, md_done, md_overlap;
      logic [31:0] stalls;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, ex_rd = '0, mem_rd = '0, wb_rd = '0;
   logic        id_uses_rs = 0, id_uses_rt = 0, id_hilo_use = 0, ex_mem_read = 0;
   logic        ex_branch_taken = 0, ex_md_start = 0, ex_md_is_div = 0;
   logic        mem_reg_write = 0, wb_reg_write = 0;
   logic        pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done, md_overlap;
   logic [1:0]  forward_a, forward_b;
   logic [31:0] stall_cycles;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // Reference model state: cycles of MULT/DIV still to run, sticky overlap, stall count.
   int          md_left = 0;
   bit          ov = 0;
   logic [31:0] stalls = 0;

   pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_hilo_use(id_hilo_use), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .forward_a(forward_a), .forward_b(forward_b), .md_busy(md_busy), .md_done(md_done),
      .md_overlap(md_overlap), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] fwd_ref(input logic [4:0] src, input stim_t s);
      if (src == 5'd0) return 2'b00;
      if (s.mem_reg_write && s.mem_rd == src) return 2'b01;
      if (s.wb_reg_write && s.wb_rd == src) return 2'b10;
      return 2'b00;
   endfunction

   function automatic stim_t quiet();
      stim_t s;
      s = '{rst: 1'b0, id_rs: 5'd0, id_rt: 5'd0, id_uses_rs: 1'b0, id_uses_rt: 1'b0,
            id_hilo_use: 1'b0, ex_rs: 5'd0, ex_rt: 5'd0, ex_rd: 5'd0, ex_mem_read: 1'b0,
            ex_branch_taken: 1'b0, ex_md_start: 1'b0, ex_md_is_div: 1'b0, mem_rd: 5'd0,
            wb_rd: 5'd0, mem_reg_write: 1'b0, wb_reg_write: 1'b0};
      return s;
   endfunction

   // Drive one cycle of inputs, queue the predicted response, then advance the model.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      bit   lu, hh, stall;
      @(posedge clk);
      #1;
      rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rs = s.id_uses_rs;
      id_uses_rt = s.id_uses_rt; id_hilo_use = s.id_hilo_use; ex_rs = s.ex_rs; ex_rt = s.ex_rt;
      ex_rd = s.ex_rd; ex_mem_read = s.ex_mem_read; ex_branch_taken = s.ex_branch_taken;
      ex_md_start = s.ex_md_start; ex_md_is_div = s.ex_md_is_div; mem_rd = s.mem_rd;
      wb_rd = s.wb_rd; mem_reg_write = s.mem_reg_write; wb_reg_write = s.wb_reg_write;
      vectors++;
      if (s.rst) begin
         md_left = 0;
         ov      = 0;
         stalls  = 0;
         e = '{pc_en: 0, ifid_en: 0, ifid_flush: 1, idex_flush: 1, fa: 2'b00, fb: 2'b00,
               md_busy: 0, md_done: 0, md_overlap: 0, stalls: 32'd0};
         exp_q.push_back(e);
         return;
      end
      e.fa         = fwd_ref(s.ex_rs, s);
      e.fb         = fwd_ref(s.ex_rt, s);
      e.md_busy    = md_left > 1;
      e.md_done    = md_left == 1;
      e.md_overlap = ov;
      e.stalls     = stalls;
      lu = s.ex_mem_read && s.ex_rd != 0 &&
           ((s.id_uses_rs && s.id_rs == s.ex_rd) || (s.id_uses_rt && s.id_rt == s.ex_rd));
      hh = e.md_busy && s.id_hilo_use;
      stall = lu || hh;
      e.pc_en      = s.ex_branch_taken || !stall;
      e.ifid_en    = e.pc_en;
      e.ifid_flush = s.ex_branch_taken;
      e.idex_flush = s.ex_branch_taken || stall;
      exp_q.push_back(e);
      if (s.ex_md_start && md_left > 0) ov = 1;
      if (md_left > 0) md_left--;
      else if (s.ex_md_start) md_left = s.ex_md_is_div ? DIV_N : MUL_N;
      if (!e.pc_en) stalls++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
      end
   endtask

   // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("pc_en",        32'(pc_en),      32'(e.pc_en));
            checkOutput("ifid_en",      32'(ifid_en),    32'(e.ifid_en));
            checkOutput("ifid_flush",   32'(ifid_flush), 32'(e.ifid_flush));
            checkOutput("idex_flush",   32'(idex_flush), 32'(e.idex_flush));
            checkOutput("forward_a",    32'(forward_a),  32'(e.fa));
            checkOutput("forward_b",    32'(forward_b),  32'(e.fb));
            checkOutput("md_busy",      32'(md_busy),    32'(e.md_busy));
            checkOutput("md_done",      32'(md_done),    32'(e.md_done));
            checkOutput("md_overlap",   32'(md_overlap), 32'(e.md_overlap));
            checkOutput("stall_cycles", stall_cycles,    e.stalls);
         end
      end
   end

   initial begin
      stim_t      s;
      logic [4:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd10;

      s = quiet(); s.rst = 1;
      repeat (2) applyStimulus(s);

      // Load-use on rs, then the bubble has moved on.
      s = quiet(); s.ex_rd = 8; s.ex_mem_read = 1; s.id_rs = 8; s.id_uses_rs = 1;
      applyStimulus(s);
      applyStimulus(quiet());
      // Load into $0 never stalls.
      s.ex_rd = 0; s.id_rs = 0; applyStimulus(s);

      // Forwarding priority and $0 exclusion.
      s = quiet(); s.mem_rd = 9; s.wb_rd = 9; s.mem_reg_write = 1; s.wb_reg_write = 1;
      s.ex_rs = 9; s.ex_rt = 9; applyStimulus(s);
      s.mem_reg_write = 0; applyStimulus(s);
      s.mem_rd = 0; s.wb_rd = 0; s.ex_rs = 0; s.ex_rt = 0; s.mem_reg_write = 1;
      applyStimulus(s);

      // MULT with MFHI waiting in ID.
      s = quiet(); s.ex_md_start = 1; applyStimulus(s);
      s = quiet(); s.id_hilo_use = 1;
      repeat (MUL_N + 1) applyStimulus(s);

      // DIV with a second start pulse mid-flight.
      s = quiet(); s.ex_md_start = 1; s.ex_md_is_div = 1; applyStimulus(s);
      for (int i = 1; i <= DIV_N + 2; i++) begin
         s = quiet();
         s.ex_md_start = (i == 10);
         applyStimulus(s);
      end

      // Taken branch overrides a load-use stall.
      s = quiet(); s.ex_branch_taken = 1; s.ex_rd = 8; s.ex_mem_read = 1;
      s.id_rt = 8; s.id_uses_rt = 1; applyStimulus(s);

      // Reset in the middle of a DIV.
      s = quiet(); s.ex_md_start = 1; s.ex_md_is_div = 1; applyStimulus(s);
      repeat (4) applyStimulus(quiet());
      s = quiet(); s.rst = 1; repeat (3) applyStimulus(s);
      repeat (DIV_N + 2) applyStimulus(quiet());

      for (int i = 0; i < 3000; i++) begin
         s = quiet();
         s.rst             = ($urandom_range(199) == 0);
         s.id_rs           = regs[$urandom_range(3)];
         s.id_rt           = regs[$urandom_range(3)];
         s.id_uses_rs      = 1'($urandom);
         s.id_uses_rt      = 1'($urandom);
         s.id_hilo_use     = ($urandom_range(2) == 0);
         s.ex_rs           = regs[$urandom_range(3)];
         s.ex_rt           = regs[$urandom_range(3)];
         s.ex_rd           = regs[$urandom_range(3)];
         s.ex_mem_read     = ($urandom_range(3) == 0);
         s.ex_branch_taken = ($urandom_range(7) == 0);
         s.ex_md_start     = ($urandom_range(11) == 0);
         s.ex_md_is_div    = ($urandom_range(3) == 0);
         s.mem_rd          = regs[$urandom_range(3)];
         s.wb_rd           = regs[$urandom_range(3)];
         s.mem_reg_write   = 1'($urandom);
         s.wb_reg_write    = 1'($urandom);
         applyStimulus(s);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Generates the EXE operand forwarding selects.
- Detects load-use hazards and stalls IF/ID.
- Flushes younger stages on taken branches.
- Schedules the multi-cycle MULT/DIV unit, stalling HI/LO consumers until the result is written.
- Keeps a stall-cycle performance counter.

Parameters:
MUL_CYCLES, 4, cycles the MULT unit stays busy (legal range 1..255)
DIV_CYCLES, 32, cycles the DIV unit stays busy (legal range 1..255)

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
id_rs, id_rt  in  5  source register numbers of the ID-stage instruction
id_uses_rs, id_uses_rt  in  1  ID-stage instruction actually reads rs / rt
id_hilo_use  in  1  ID-stage instruction is MFHI/MFLO/MULT/DIV (needs or writes HI/LO)
ex_rs, ex_rt  in  5  source register numbers of the EXE-stage instruction
ex_rd  in  5  destination of the EXE-stage instruction
ex_mem_read  in  1  EXE-stage instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EXE
ex_md_start  in  1  MULT/DIV is in EXE this cycle (one-cycle pulse per instruction)
ex_md_is_div  in  1  qualifies ex_md_start: 1 = DIV, 0 = MULT
mem_rd, wb_rd  in  5  destinations in MEM / WB
mem_reg_write, wb_reg_write  in  1  MEM / WB instruction writes the register file
pc_en  out  1  PC register enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID register loads a NOP
idex_flush  out  1  ID/EX register loads a NOP (bubble)
forward_a, forward_b  out  2  EXE operand selects: 00 = regfile, 01 = MEM result, 10 = WB result
md_busy  out  1  MULT/DIV unit is computing
md_done  out  1  one-cycle pulse: HI/LO write enable
md_overlap  out  1  sticky: ex_md_start was seen while busy
stall_cycles  out  32  count of cycles with pc_en=0

Behaviour:
- Reset (async, rst=1):
  - State is IDLE, cnt=0, md_overlap=0, stall_cycles=0.
  - While rst is high, the outputs are forced: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, forward_a/b=00, md_busy=0, md_done=0.
  - Reset mid-operation abandons any MULT/DIV in flight, and no md_done is produced.
- Forwarding (combinational):
  - forward_a = 01 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs.
  - Otherwise forward_a = 10 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs.
  - Otherwise forward_a = 00.
  - MEM has priority over WB. forward_b is identical using ex_rt.
- Load-use (lu): ex_mem_read && ex_rd!=0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- HI/LO hazard (hh): md_busy && id_hilo_use.
- Stall = lu || hh. When stalling: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
- Taken branch: ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1. The branch overrides any stall in the same cycle.
- Otherwise: pc_en=1, ifid_en=1, both flushes 0.
- MULT/DIV FSM, states IDLE and BUSY:
  - IDLE, ex_md_start=1: go to BUSY; cnt <= (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
  - BUSY: if cnt==0, go to IDLE; otherwise cnt <= cnt-1.
  - md_done = (BUSY && cnt==0). md_busy = (BUSY && cnt!=0).
  - The unit is in BUSY for exactly N cycles; md_done is high in the Nth.
  - In the md_done cycle there is no HI/LO stall. HI/LO is written at that edge, and a waiting MFHI enters EXE afterwards.
- ex_md_start while in BUSY (including the done cycle): ignored and md_overlap <= 1. md_overlap clears only on reset.
- stall_cycles increments on each rising edge where rst=0 and pc_en=0. It wraps from 0xFFFFFFFF to 0.
- Register $0 is never forwarded and never triggers a load-use stall.

Test Plan:
1. LW $t0 in EXE (ex_rd=8, ex_mem_read=1), ID reads rs=8 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle no stall; stall_cycles=1.
2. mem_rd=wb_rd=9 both writing, ex_rs=9 -> forward_a=01. With mem_reg_write=0 -> forward_a=10. With rd=0 -> 00.
3. ex_md_start=1, ex_md_is_div=0 (MUL_CYCLES=4) -> md_busy for 3 cycles, md_done in the 4th. MFHI held in ID the whole time (id_hilo_use=1) -> 3 stall cycles, then it proceeds.
4. DIV start -> md_done exactly 32 cycles later. A second ex_md_start pulse injected in cycle 10 is ignored: md_done still at cycle 32, md_overlap=1.
5. ex_branch_taken=1 together with a load-use hazard -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cycles unchanged.
6. Assert rst in cycle 5 of a DIV -> md_busy=0 immediately, no md_done afterwards, stall_cycles=0, pc_en=0 until rst deasserts.
